// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-and-add-3),
// one input bit per clock. Feeds the seg7 digit decoders.
//
// Ports:
//   clk      - system clock, rising edge
//   resetN   - asynchronous active-low reset
//   start    - conversion request, sampled only while idle
//   bin_in   - unsigned binary value, captured on the accepted start edge
//   busy     - high while a conversion is in progress
//   done     - one-cycle pulse when a new result is on bcd_out
//   bcd_out  - DIGITS BCD digits, digit i at [4i+3:4i], digit 0 least significant
//   lz_mask  - bit i=1 marks digit i as a leading zero; bit 0 is always 0
//   overflow - value did not fit in DIGITS digits; valid with bcd_out
module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 5
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     lz_mask,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [CW-1:0]     LAST   = CW'(IN_WIDTH - 1);
  localparam logic [DIGITS-1:0] LZ_RST = ~DIGITS'(1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]          state;
  logic [IN_WIDTH-1:0] bin_sr;
  logic [BW-1:0]       scr;
  logic                ovf_scr;
  logic [CW-1:0]       cnt;

  logic [BW-1:0]       adj;
  logic [BW-1:0]       scr_nxt;
  logic [IN_WIDTH-1:0] bin_nxt;
  logic                carry;
  logic [DIGITS-1:0]   lz_nxt;
  logic                zero_run;

  // One double-dabble step. The bit leaving the top nibble after the +3
  // adjust is exactly the decimal carry out of the most significant digit,
  // so accumulating it gives "value >= 10^DIGITS" while the kept nibbles
  // hold the value modulo 10^DIGITS.
  always_comb begin
    adj = scr;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    carry   = adj[BW-1];
    scr_nxt = {adj[BW-2:0], bin_sr[IN_WIDTH-1]};
    bin_nxt = bin_sr << 1;

    // Leading-zero run scanned from the top digit down; digit 0 never blanks.
    lz_nxt   = '0;
    zero_run = 1'b1;
    for (int unsigned j = 0; j < DIGITS - 1; j++) begin
      zero_run = zero_run & (scr_nxt[4*(DIGITS-1-j) +: 4] == 4'd0);
      lz_nxt[DIGITS-1-j] = zero_run;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd_out  <= '0;
      lz_mask  <= LZ_RST;
      bin_sr   <= '0;
      scr      <= '0;
      ovf_scr  <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            bin_sr  <= bin_in;
            scr     <= '0;
            ovf_scr <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bin_sr  <= bin_nxt;
          scr     <= scr_nxt;
          ovf_scr <= ovf_scr | carry;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            bcd_out  <= scr_nxt;
            lz_mask  <= lz_nxt;
            overflow <= ovf_scr | carry;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        resetN;

  logic        start;
  logic [15:0] bin_in;
  logic        busy, done, overflow;
  logic [19:0] bcd_out;
  logic [4:0]  lz_mask;

  logic        start8;
  logic [7:0]  bin8;
  logic        busy8, done8, overflow8;
  logic [7:0]  bcd8;
  logic [1:0]  lz8;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.IN_WIDTH(16), .DIGITS(5)) dut16 (
    .clk(clk), .resetN(resetN), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .lz_mask(lz_mask),
    .overflow(overflow)
  );

  bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(2)) dut8 (
    .clk(clk), .resetN(resetN), .start(start8), .bin_in(bin8),
    .busy(busy8), .done(done8), .bcd_out(bcd8), .lz_mask(lz8),
    .overflow(overflow8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 16-bit conversion: checks busy/done/hold every cycle, then result.
  task automatic conv16(input logic [15:0] v, input logic [19:0] prev_bcd,
                        input logic [19:0] exp_bcd, input logic [4:0] exp_lz,
                        input string tag);
    bin_in = v;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    bin_in = 16'hA5A5;
    for (int i = 1; i <= 15; i++) begin
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      chk({tag, " nodone"}, {31'd0, done}, 32'd0);
      chk({tag, " hold"}, {12'd0, bcd_out}, {12'd0, prev_bcd});
      tick();
    end
    chk({tag, " busy_last"}, {31'd0, busy}, 32'd1);
    tick();
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, " bcd"}, {12'd0, bcd_out}, {12'd0, exp_bcd});
    chk({tag, " lz"}, {27'd0, lz_mask}, {27'd0, exp_lz});
    chk({tag, " ovf"}, {31'd0, overflow}, 32'd0);
    tick();
    chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic conv8(input logic [7:0] v, input logic [7:0] exp_bcd,
                       input logic [1:0] exp_lz, input logic exp_ovf,
                       input string tag);
    bin8   = v;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    bin8   = 8'h3C;
    for (int i = 1; i <= 7; i++) begin
      chk({tag, " busy"}, {31'd0, busy8}, 32'd1);
      chk({tag, " nodone"}, {31'd0, done8}, 32'd0);
      tick();
    end
    tick();
    chk({tag, " done"}, {31'd0, done8}, 32'd1);
    chk({tag, " bcd"}, {24'd0, bcd8}, {24'd0, exp_bcd});
    chk({tag, " lz"}, {30'd0, lz8}, {30'd0, exp_lz});
    chk({tag, " ovf"}, {31'd0, overflow8}, {31'd0, exp_ovf});
    tick();
  endtask

  initial begin
    resetN = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    start8 = 1'b0;
    bin8   = '0;
    tick();
    tick();
    resetN = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Reset state
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst bcd", {12'd0, bcd_out}, 32'h0);
    chk("rst lz", {27'd0, lz_mask}, 32'b11110);
    chk("rst ovf", {31'd0, overflow}, 32'd0);
    chk("rst lz8", {30'd0, lz8}, 32'b10);

    conv16(16'd1234,  20'h00000, 20'h01234, 5'b10000, "c1234");
    conv16(16'd65535, 20'h01234, 20'h65535, 5'b00000, "c65535");
    conv16(16'd0,     20'h65535, 20'h00000, 5'b11110, "c0");
    conv16(16'd10,    20'h00000, 20'h00010, 5'b11100, "c10");

    // start held high: done every 17 cycles, start ignored while busy
    bin_in = 16'd9;
    start  = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int i = 1; i <= 15; i++) begin
        chk("held busy", {31'd0, busy}, 32'd1);
        chk("held nodone", {31'd0, done}, 32'd0);
        chk("held hold", {12'd0, bcd_out}, (k == 0) ? 32'h10 : 32'h9);
        tick();
      end
      tick();
      chk("held done", {31'd0, done}, 32'd1);
      chk("held bcd", {12'd0, bcd_out}, 32'h9);
      chk("held lz", {27'd0, lz_mask}, 32'b11110);
      if (k == 2) start = 1'b0;
      tick();
      chk("held reaccept", {31'd0, busy}, (k == 2) ? 32'd0 : 32'd1);
      chk("held done_pulse", {31'd0, done}, 32'd0);
    end

    // Reset during shift 7 aborts the conversion
    bin_in = 16'd500;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    #2;
    resetN = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort bcd", {12'd0, bcd_out}, 32'h0);
    chk("abort lz", {27'd0, lz_mask}, 32'b11110);
    chk("abort ovf", {31'd0, overflow}, 32'd0);
    tick();
    resetN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("abort nodone", {31'd0, done}, 32'd0);
      tick();
    end
    conv16(16'd42, 20'h00000, 20'h00042, 5'b11100, "c42");

    // Narrow instance: overflow and two-digit masks
    conv8(8'd200, 8'h00, 2'b10, 1'b1, "n200");
    conv8(8'd99,  8'h99, 2'b00, 1'b0, "n99");
    conv8(8'd7,   8'h07, 2'b10, 1'b0, "n7");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
